regfile_2r1w: RTL and testbench

REGFILE_2R1W -- requirements
Module: regfile_2r1w

---
 rtl/regfile_2r1w.sv | 90 +++++++++
 tb/tb_regfile_2r1w.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// ============================================================================
// Module   : regfile_2r1w
// Brief    : 2-read / 1-write register file with registered reads and
//            write-to-read forwarding. Build macro REGFILE_ZERO_REG_EN
//            hard-wires entry DEPTH-1 to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr0,
    input  logic [$clog2(DEPTH)-1:0] rd_addr1,
    output logic [WIDTH-1:0]         rd_data0,
    output logic [WIDTH-1:0]         rd_data1,
    output logic                     rd_valid
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] rd_next0;
    logic [WIDTH-1:0] rd_next1;

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return ZERO_REG && (a == LAST_ADDR);
    endfunction

    // A write is valid only in range and never to the hard-wired zero entry
    assign wr_ok = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);

    always_comb begin
        rd_next0 = '0;
        rd_next1 = '0;
        if (in_range(rd_addr0) && !is_zero_reg(rd_addr0)) begin
            rd_next0 = (wr_ok && (wr_addr == rd_addr0)) ? wr_data : mem[rd_addr0];
        end
        if (in_range(rd_addr1) && !is_zero_reg(rd_addr1)) begin
            rd_next1 = (wr_ok && (wr_addr == rd_addr1)) ? wr_data : mem[rd_addr1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data0 <= rd_next0;
                rd_data1 <= rd_next1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// ============================================================================
// Module   : tb_regfile_2r1w
// Brief    : Directed self-checking bench for regfile_2r1w (DEPTH 32 and 20).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        rd_en;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [63:0] rd_data0, rd_data1;
    logic        rd_valid;
    logic [63:0] s_data0, s_data1;
    logic        s_valid;

    int tests  = 0;
    int failed = 0;

    regfile_2r1w #(.WIDTH(64), .DEPTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_valid(rd_valid)
    );

    // Same stimulus into a non-power-of-two instance; AW is 5 for both
    regfile_2r1w #(.WIDTH(64), .DEPTH(20)) dut20 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(s_data0), .rd_data1(s_data1), .rd_valid(s_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                         input logic re, input logic [4:0] ra0, input logic [4:0] ra1);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr0 = ra0; rd_addr1 = ra1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0);
        #1;
        check("reset_rd0", rd_data0, 64'd0);
        check("reset_valid", {63'd0, rd_valid}, 64'd0);
        step();
        step();
        reset_n = 1'b1;

        // Populate, read back, then reset asynchronously between edges
        drive(1'b1, 5'd0, 64'h11, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd7, 64'h77, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd7);
        step();
        check("pre_reset_rd0", rd_data0, 64'h11);
        check("pre_reset_rd1", rd_data1, 64'h77);
        check("pre_reset_valid", {63'd0, rd_valid}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_rd0", rd_data0, 64'd0);
        check("async_reset_rd1", rd_data1, 64'd0);
        check("async_reset_valid", {63'd0, rd_valid}, 64'd0);
        step();
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd7);
        step();
        check("post_reset_rd0", rd_data0, 64'd0);
        check("post_reset_rd1", rd_data1, 64'd0);
        check("post_reset_valid", {63'd0, rd_valid}, 64'd1);

        // Write then read on the next cycle
        drive(1'b1, 5'd3, 64'hDEADBEEF_CAFEF00D, 1'b0, 5'd0, 5'd0);
        step();
        check("no_rd_valid", {63'd0, rd_valid}, 64'd0);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        step();
        check("wr_rd_rd0", rd_data0, 64'hDEADBEEF_CAFEF00D);
        check("wr_rd_rd1", rd_data1, 64'hDEADBEEF_CAFEF00D);

        // Forwarding, one port then both ports
        drive(1'b1, 5'd6, 64'h66, 1'b0, 5'd0, 5'd0);
        step();
        drive(1'b1, 5'd5, 64'h55, 1'b1, 5'd5, 5'd6);
        step();
        check("fwd_rd0", rd_data0, 64'h55);
        check("fwd_rd1_old", rd_data1, 64'h66);
        drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 5'd9);
        step();
        check("fwd_both_rd0", rd_data0, 64'h99);
        check("fwd_both_rd1", rd_data1, 64'h99);

        // Top entry: zero register when enabled, ordinary otherwise
        drive(1'b1, 5'd31, {64{1'b1}}, 1'b1, 5'd31, 5'd31);
        step();
        check("top_same_cycle", rd_data0, ZR ? 64'd0 : {64{1'b1}});
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd0);
        step();
        check("top_later_read", rd_data0, ZR ? 64'd0 : {64{1'b1}});
        check("top_port1_addr0", rd_data1, 64'd0);

        // Hold while rd_en is low, even as the read address is rewritten
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        step();
        check("hold_setup", rd_data0, 64'hDEADBEEF_CAFEF00D);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd3, 64'hAAAA + 64'(i), 1'b0, 5'd3, 5'd3);
            step();
            check("hold_rd0", rd_data0, 64'hDEADBEEF_CAFEF00D);
            check("hold_rd1", rd_data1, 64'hDEADBEEF_CAFEF00D);
            check("hold_valid", {63'd0, rd_valid}, 64'd0);
        end
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3);
        step();
        check("hold_after_write", rd_data0, 64'hAAAC);

        // Out-of-range write/read on the DEPTH=20 instance
        drive(1'b1, 5'd25, 64'hBAD, 1'b1, 5'd25, 5'd5);
        step();
        check("oor_fwd_rd0", s_data0, 64'd0);
        check("oor_other_rd1", s_data1, 64'h55);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd25, 5'd9);
        step();
        check("oor_read_rd0", s_data0, 64'd0);
        check("oor_entry9", s_data1, 64'h99);
        check("oor_valid", {63'd0, s_valid}, 64'd1);

        // Reset landing between edges during a write of addr 2
        drive(1'b1, 5'd2, 64'h1234, 1'b1, 5'd2, 5'd2);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_reset_rd0", rd_data0, 64'd0);
        check("mid_reset_rd1", rd_data1, 64'd0);
        check("mid_reset_valid", {63'd0, rd_valid}, 64'd0);
        step();
        check("mid_reset_edge_valid", {63'd0, rd_valid}, 64'd0);
        reset_n = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 5'd3);
        step();
        check("mid_reset_addr2", rd_data0, 64'd0);
        check("mid_reset_addr3", rd_data1, 64'd0);
        check("mid_reset_rd_valid", {63'd0, rd_valid}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

`default_nettype wire
